// File: rtl/risc_pkg.sv
// Shared definitions for the accumulator RISC core: opcodes, sequencer states,
// and the datapath strobe bundle.
package risc_pkg;

  localparam int unsigned OPCODE_W = 3;

  typedef enum logic [OPCODE_W-1:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_e;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_S0   = 4'd1,
    ST_S1   = 4'd2,
    ST_S2   = 4'd3,
    ST_S3   = 4'd4,
    ST_S4   = 4'd5,
    ST_S5   = 4'd6,
    ST_S6   = 4'd7,
    ST_S7   = 4'd8,
    ST_WAIT = 4'd9,
    ST_HALT = 4'd10
  } state_e;

  typedef struct packed {
    logic load_ir;
    logic inc_pc;
    logic rd;
    logic wr;
    logic datactl_ena;
    logic load_acc;
    logic load_pc;
    logic halt;
  } strobes_t;

  // Instructions that read memory into the accumulator path (ALU ops and LDA).
  function automatic logic is_acc_op(opcode_e op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/risc_ctrl_seq_if.sv
// Sequencer <-> clock generator / datapath signal bundle.
interface risc_ctrl_seq_if;
  import risc_pkg::*;

  logic                fetch;
  logic [OPCODE_W-1:0] opcode;
  logic                zero;
  logic                load_ir;
  logic                inc_pc;
  logic                rd;
  logic                wr;
  logic                datactl_ena;
  logic                load_acc;
  logic                load_pc;
  logic                halt;
  logic                phase_err;
  logic [3:0]          phase;

  modport master (
    input  fetch, opcode, zero,
    output load_ir, inc_pc, rd, wr, datactl_ena, load_acc, load_pc, halt,
           phase_err, phase
  );

  modport slave (
    output fetch, opcode, zero,
    input  load_ir, inc_pc, rd, wr, datactl_ena, load_acc, load_pc, halt,
           phase_err, phase
  );

endinterface

// File: rtl/risc_edge_det.sv
// Rising-edge detector: one registered copy of the input, combinational pulse.
module risc_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic i_sig,
  output logic o_rise
);

  logic r_sig_q;

  always_ff @(posedge clk) begin
    if (reset) r_sig_q <= 1'b0;
    else       r_sig_q <= i_sig;
  end

  assign o_rise = i_sig & ~r_sig_q;

endmodule

// File: rtl/risc_ctrl_seq.sv
// 8-phase instruction sequencer: steps S0..S7 on fetch rises and drives
// registered datapath strobes decoded from the state being entered.
module risc_ctrl_seq
  import risc_pkg::*;
#(
  parameter bit          RESYNC_EN = 1'b1,
  parameter int unsigned OPW       = 3
) (
  input  logic            clk,
  input  logic            reset,
  risc_ctrl_seq_if.master bus
);

  state_e         r_state;
  state_e         w_state_nxt;
  strobes_t       r_strb;
  strobes_t       w_strb_nxt;
  logic           r_zero_l;
  logic           r_phase_err;
  logic           w_rise;
  logic           w_in_seq;
  logic           w_misalign;
  logic           w_zero_eff;
  logic [OPW-1:0] w_opcode_raw;
  opcode_e        w_op;

  risc_edge_det u_edge_det (
    .clk    (clk),
    .reset  (reset),
    .i_sig  (bus.fetch),
    .o_rise (w_rise)
  );

  assign w_opcode_raw = bus.opcode;
  assign w_op         = opcode_e'(w_opcode_raw);
  assign w_in_seq     = (r_state >= ST_S0) && (r_state <= ST_S6);
  assign w_misalign   = w_rise & w_in_seq;
  // S4 strobes are decoded while still in S3, before zero_l has captured zero.
  assign w_zero_eff   = (r_state == ST_S3) ? bus.zero : r_zero_l;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE, ST_WAIT: if (w_rise) w_state_nxt = ST_S0;
      ST_S7:            w_state_nxt = w_rise ? ST_S0 : ST_WAIT;
      ST_HALT:          w_state_nxt = ST_HALT;
      ST_S0, ST_S1, ST_S2, ST_S3, ST_S4, ST_S5, ST_S6: begin
        if (w_misalign && RESYNC_EN)
          w_state_nxt = ST_S0;
        else if ((r_state == ST_S3) && (w_op == OP_HLT))
          w_state_nxt = ST_HALT;
        else
          w_state_nxt = state_e'(r_state + 4'd1);
      end
      default:          w_state_nxt = ST_IDLE;
    endcase

    w_strb_nxt = '0;
    case (w_state_nxt)
      ST_S0, ST_S1: begin
        w_strb_nxt.rd      = 1'b1;
        w_strb_nxt.load_ir = 1'b1;
        w_strb_nxt.inc_pc  = 1'b1;
      end
      ST_S4: begin
        w_strb_nxt.rd          = is_acc_op(w_op);
        w_strb_nxt.datactl_ena = (w_op == OP_STO);
        w_strb_nxt.load_pc     = (w_op == OP_JMP);
        w_strb_nxt.inc_pc      = (w_op == OP_SKZ) && w_zero_eff;
      end
      ST_S5: begin
        w_strb_nxt.rd          = is_acc_op(w_op);
        w_strb_nxt.load_acc    = is_acc_op(w_op);
        w_strb_nxt.datactl_ena = (w_op == OP_STO);
        w_strb_nxt.wr          = (w_op == OP_STO);
        w_strb_nxt.load_pc     = (w_op == OP_JMP);
      end
      ST_S6: begin
        w_strb_nxt.rd          = is_acc_op(w_op);
        w_strb_nxt.datactl_ena = (w_op == OP_STO);
        w_strb_nxt.inc_pc      = (w_op == OP_SKZ) && w_zero_eff;
      end
      ST_HALT: w_strb_nxt.halt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_strb      <= '0;
      r_zero_l    <= 1'b0;
      r_phase_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_strb      <= w_strb_nxt;
      r_phase_err <= w_misalign;
      if (r_state == ST_S3) r_zero_l <= bus.zero;
    end
  end

  assign bus.load_ir     = r_strb.load_ir;
  assign bus.inc_pc      = r_strb.inc_pc;
  assign bus.rd          = r_strb.rd;
  assign bus.wr          = r_strb.wr;
  assign bus.datactl_ena = r_strb.datactl_ena;
  assign bus.load_acc    = r_strb.load_acc;
  assign bus.load_pc     = r_strb.load_pc;
  assign bus.halt        = r_strb.halt;
  assign bus.phase_err   = r_phase_err;
  assign bus.phase       = r_state;

endmodule

// File: tb/tb_risc_ctrl_seq.sv
// Scoreboard bench: two sequencers (RESYNC_EN=0/1) share stimulus; a reference
// model pushes per-cycle expectations, a monitor pops and compares.
module tb_risc_ctrl_seq;

  localparam int N_INSTR = 150;
  localparam int N_DIR   = 11;
  localparam int P_IDLE  = -2;
  localparam int P_WAIT  = -1;
  localparam int P_HALT  = 8;

  logic clk;
  logic reset;

  risc_ctrl_seq_if if0 ();
  risc_ctrl_seq_if if1 ();

  risc_ctrl_seq #(.RESYNC_EN(1'b0), .OPW(3)) u_dut0 (.clk(clk), .reset(reset), .bus(if0));
  risc_ctrl_seq #(.RESYNC_EN(1'b1), .OPW(3)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [12:0] got0, got1;
  assign got0 = {if0.phase, if0.load_ir, if0.inc_pc, if0.rd, if0.wr, if0.datactl_ena,
                 if0.load_acc, if0.load_pc, if0.halt, if0.phase_err};
  assign got1 = {if1.phase, if1.load_ir, if1.inc_pc, if1.rd, if1.wr, if1.datactl_ena,
                 if1.load_acc, if1.load_pc, if1.halt, if1.phase_err};

  logic [12:0] q0[$];
  logic [12:0] q1[$];
  int n_vec = 0;
  int n_err = 0;
  int mon_cyc = 0;

  // Directed opening: LDA x2, STO, SKZ z=1/0, misaligned rises in S4/S5/S6, AND, JMP, HLT.
  int unsigned dir_op[N_DIR]  = '{5, 5, 6, 1, 1, 6, 2, 4, 3, 7, 0};
  int unsigned dir_z[N_DIR]   = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 0};
  int unsigned dir_inj[N_DIR] = '{0, 0, 0, 0, 0, 5, 6, 7, 0, 0, 0};

  // Model position: P_IDLE, P_WAIT, 0..7 = S0..S7, P_HALT.
  int m_pos[2];
  bit m_zl[2];
  bit m_fq;

  function automatic logic [12:0] expv(int pos, logic [2:0] op, bit zl, bit err);
    logic [3:0] ph;
    bit li, ip, rd, wr, de, la, lp, hl, acc, sto, jmp, skz;
    {li, ip, rd, wr, de, la, lp, hl} = '0;
    acc = (op >= 3'd2) && (op <= 3'd5);
    sto = (op == 3'd6);
    jmp = (op == 3'd7);
    skz = (op == 3'd1);
    if (pos == P_IDLE)      ph = 4'd0;
    else if (pos == P_WAIT) ph = 4'd9;
    else if (pos == P_HALT) ph = 4'd10;
    else                    ph = 4'(pos + 1);
    case (pos)
      0, 1: begin rd = 1; li = 1; ip = 1; end
      4: begin rd = acc; de = sto; lp = jmp; ip = skz && zl; end
      5: begin rd = acc; la = acc; de = sto; wr = sto; lp = jmp; end
      6: begin rd = acc; de = sto; ip = skz && zl; end
      P_HALT: hl = 1;
      default: ;
    endcase
    return {ph, li, ip, rd, wr, de, la, lp, hl, err};
  endfunction

  task automatic chk(input int d, input logic [12:0] got, input logic [12:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL dut%0d cyc%0d: got phase=%0d strobes=%b, want phase=%0d strobes=%b",
               d, mon_cyc, got[12:9], got[8:0], exp[12:9], exp[8:0]);
    end
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      mon_cyc++;
      if (q0.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL dut0 cyc%0d: scoreboard empty, got %b want an entry", mon_cyc, got0);
      end else chk(0, got0, q0.pop_front());
      if (q1.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL dut1 cyc%0d: scoreboard empty, got %b want an entry", mon_cyc, got1);
      end else chk(1, got1, q1.pop_front());
    end
  end

  initial begin : driver
    int cnt, rst_left, halt_cyc, n_instr, tail, inj_off, old;
    bit inj_now, rst, fet, rise, err;
    logic [2:0] op;
    bit z;
    logic [12:0] e;

    cnt = 3; rst_left = 3; halt_cyc = 0; n_instr = 0; tail = 0; inj_off = 0;
    inj_now = 0; op = 3'd0; z = 0; m_fq = 0;
    for (int d = 0; d < 2; d++) begin m_pos[d] = P_IDLE; m_zl[d] = 0; end

    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc != 0) @(negedge clk);
      rst = (rst_left > 0);
      if (rst_left > 0) rst_left--;
      fet  = (cnt < 4);
      rise = fet & ~m_fq;

      if (rise && !rst && !inj_now) begin
        if (n_instr < N_DIR) begin
          op = 3'(dir_op[n_instr]); z = dir_z[n_instr][0]; inj_off = int'(dir_inj[n_instr]);
        end else begin
          op = 3'($urandom_range(0, 7));
          z = 1'($urandom_range(0, 1));
          inj_off = (op != 3'd0 && $urandom_range(0, 5) == 0) ? int'($urandom_range(5, 7)) : 0;
        end
        n_instr++;
      end

      reset = rst;
      if0.fetch = fet; if0.opcode = op; if0.zero = z;
      if1.fetch = fet; if1.opcode = op; if1.zero = z;

      for (int d = 0; d < 2; d++) begin
        if (rst) begin
          m_pos[d] = P_IDLE; m_zl[d] = 0; err = 0;
        end else begin
          old = m_pos[d];
          err = rise && old >= 0 && old <= 6;
          if (old == P_HALT) m_pos[d] = P_HALT;
          else if (old >= 0 && old <= 6) begin
            if (rise && d == 1)              m_pos[d] = 0;
            else if (old == 3 && op == 3'd0) m_pos[d] = P_HALT;
            else                             m_pos[d] = old + 1;
          end else if (rise)   m_pos[d] = 0;
          else if (old == 7)   m_pos[d] = P_WAIT;
          if (old == 3) m_zl[d] = z;
        end
        e = expv(m_pos[d], op, m_zl[d], err);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
      m_fq = rst ? 1'b0 : fet;

      if (m_pos[1] == P_HALT) begin
        halt_cyc++;
        if (halt_cyc == 20) rst_left = 3;
      end else halt_cyc = 0;

      inj_now = 0;
      cnt = (cnt + 1) % 8;
      if (inj_off != 0 && cnt == inj_off) begin
        cnt = 0; inj_off = 0; inj_now = 1;
      end

      if (n_instr >= N_INSTR) tail++;
      if (tail > 10) break;
    end

    @(posedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/risc_ctrl_seq.md
Name: risc_ctrl_seq

Overview:
- Instruction sequencer for the 8-bit accumulator RISC core.
- Consumes the `fetch` phase strobe from the clock generator, which rises once every 8 `clk` cycles, and steps an 8-phase instruction cycle, one phase per `clk`.
- Decodes the 3-bit opcode and drives the datapath strobes for PC, IR, ACC, memory and data bus.
- Sits between the clock generator and the PC, IR, ACC, ALU and memory interface.

Parameters:
- RESYNC_EN, 1: 1 = realign to S0 on a misaligned `fetch` rise; 0 = flag the rise only and keep sequencing.
- OPW, 3: opcode width. Fixed at 3; changing it is unsupported.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- fetch  in  1  phase strobe from the clock generator; 50% duty, period 8 clk.
- opcode  in  3  IR[15:13]; valid from phase S2 onward.
- zero  in  1  accumulator == 0; sampled in S3.
- load_ir  out  1  IR byte load (high byte in S0, low byte in S1).
- inc_pc  out  1  PC += 1 this cycle.
- rd  out  1  memory read enable.
- wr  out  1  memory write strobe.
- datactl_ena  out  1  drive ACC onto the data bus.
- load_acc  out  1  ACC load from ALU result.
- load_pc  out  1  PC load from IR[12:0].
- halt  out  1  sticky halt indication.
- phase_err  out  1  one-cycle pulse on a misaligned fetch rise.
- phase  out  4  current state encoding, for debug and bench use.

Behaviour:
- Reset
  - Reset sets state = IDLE, clears the `fetch` delay register, and sets all outputs to 0.
  - Reset overrides everything, including HALT and mid-instruction states.
- Edge detection
  - fetch_q <= fetch every cycle.
  - rise = fetch & ~fetch_q.
- Timing of outputs
  - Outputs are registered.
  - They are computed from the next state and asserted for exactly the cycle in which `phase` shows that state.
- States: IDLE, S0..S7, WAIT, HALT.
- Transitions
  - IDLE: rise -> S0. Otherwise stay.
  - S0 -> S1 -> ... -> S6 -> S7: one step per clk.
  - S7: rise -> S0. No rise -> WAIT.
  - WAIT: rise -> S0. Otherwise stay. All strobes 0.
  - A rise while in S0..S6:
    - `phase_err` pulses in the next cycle.
    - If RESYNC_EN=1, next state is S0 and the current instruction is abandoned. No wr is issued after the abort.
    - If RESYNC_EN=0, the sequence continues normally.
  - S3 with opcode == HLT: next state is HALT. The HALT state sets `halt`=1; all other strobes are 0 until reset. Fetch rises are ignored in HALT.
  - Nominal alignment: rise detected at cycle t gives S0 at t+1, S7 at t+8, next rise detected at t+8, next S0 at t+9. No WAIT cycles occur.
- Opcodes (3 bits): HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- Strobes per state (any strobe not listed is 0):
  - S0: rd, load_ir, inc_pc.
  - S1: rd, load_ir, inc_pc.
  - S2: none.
  - S3: none. The HLT decision is taken here; `zero` is latched into zero_l here.
  - S4:
    - ADD/AND/XOR/LDA: rd.
    - STO: datactl_ena.
    - JMP: load_pc.
    - SKZ with zero_l=1: inc_pc.
  - S5:
    - ADD/AND/XOR/LDA: rd, load_acc.
    - STO: datactl_ena, wr.
    - JMP: load_pc.
  - S6:
    - ADD/AND/XOR/LDA: rd.
    - STO: datactl_ena.
    - SKZ with zero_l=1: inc_pc.
  - S7: none.
- Per-instruction counts
  - SKZ with zero_l=1 gives 2 extra inc_pc pulses, skipping a 2-byte instruction.
  - wr is asserted only in S5 and only for STO: exactly one pulse per STO.
  - load_acc is asserted exactly once per ALU or LDA instruction.
- Invariants
  - wr and rd are never both 1.
  - load_pc and inc_pc are never both 1.

Decomposition:
- risc_pkg (shared) holds:
  - opcode constants HLT..JMP;
  - the state encoding localparams: IDLE=0, S0..S7=1..8, WAIT=9, HALT=10.
- The clock generator's bench also imports the opcode constants from risc_pkg.
- One natural sub-module: risc_edge_det (fetch_q register plus the rise pulse). It is reusable for the clock-generator alignment checks.

Test Plan:
- Reset held for 3 cycles, then released with `fetch` running -> all outputs 0 until the first rise; `phase`=S0 on the next cycle; the S0..S7 sequence repeats every 8 clk with no WAIT cycles.
- LDA (opcode=5), 2 instructions back to back -> per instruction: rd high in S0, S1, S4, S5, S6; load_ir high in S0 and S1; inc_pc high in S0 and S1; load_acc high only in S5. Totals: 2 load_ir, 2 inc_pc, 1 load_acc per instruction.
- STO (opcode=6) -> datactl_ena high in S4..S6; wr a single pulse in S5; rd stays 0 in S4..S7.
- SKZ (opcode=1) with zero=1, then with zero=0 -> 4 inc_pc per instruction vs 2; load_pc stays 0 in both cases.
- HLT (opcode=0) -> `halt`=1 from the cycle after S3 and held for 20 cycles with fetch still toggling; all strobes stay 0; reset clears `halt` to 0.
- Extra fetch rise injected while in S4, RESYNC_EN=1 -> `phase_err` is a 1-cycle pulse, `phase` is S0 in that same cycle, and the abandoned STO produces no wr. With RESYNC_EN=0 -> the pulse still occurs and the sequence continues to S5.
